mem_stage: RTL

- Memory-access stage of the multi-cycle RV32I core. Sits between execute and write-back.
- For loads and stores it drives the word-organised data memory. For all other instructions it passes the ALU result through unchanged.
- The value on `result` feeds the write-back stage's data input. A pulse on `completed` drives the write-back stage's `enabled`.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage driving a word-organised data memory.
// Build option: MEM_MISALIGN_CHECK_EN traps misaligned H/W accesses.
module mem_stage #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result,
  output logic        completed,
  output logic        misaligned
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MEM_LATENCY - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    lane_q;
  logic          is_b_q;
  logic          is_h_q;
  logic          sx_q;

  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          trap;
  logic [1:0]    lo;
  logic [3:0]    we_n;
  logic [31:0]   wdata_n;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_val;

  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign is_w = ~is_b & ~is_h;

`ifdef MEM_MISALIGN_CHECK_EN
  assign trap = (is_h & addr[0]) |
                (is_w & (|addr[1:0]));
`else
  assign trap = 1'b0;
`endif

  // without the trap, low bits are forced to the access alignment
  always_comb begin
    lo = addr[1:0];
    if (is_h) lo[0] = 1'b0;
    if (is_w) lo = 2'b00;
  end

  always_comb begin
    we_n    = 4'b1111;
    wdata_n = store_data;
    unique case (1'b1)
      is_b: begin
        we_n    = 4'b0001 << lo;
        wdata_n = {4{store_data[7:0]}};
      end
      is_h: begin
        we_n    = 4'b0011 << lo;
        wdata_n = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lb = mem_rdata[{lane_q, 3'b000} +: 8];
  assign lh = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = mem_rdata;
    unique case (1'b1)
      is_b_q:  ld_val = {{24{sx_q & lb[7]}}, lb};
      is_h_q:  ld_val = {{16{sx_q & lh[15]}}, lh};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lane_q     <= 2'b00;
      is_b_q     <= 1'b0;
      is_h_q     <= 1'b0;
      sx_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= '0;
      result     <= '0;
      completed  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      completed  <= 1'b0;
      misaligned <= 1'b0;
      mem_we     <= '0;
      unique case (state)
        S_IDLE: begin
          if (enabled) begin
            lane_q <= lo;
            is_b_q <= is_b;
            is_h_q <= is_h;
            sx_q   <= ~funct3[2];
            cnt    <= '0;
            if (!is_load && !is_store) begin
              state     <= S_DONE;
              completed <= 1'b1;
              result    <= alu_result;
            end else if (trap) begin
              state      <= S_DONE;
              completed  <= 1'b1;
              misaligned <= 1'b1;
              result     <= '0;
            end else begin
              mem_addr <= addr[31:2];
              if (is_load) begin
                state <= S_LOAD;
              end else begin
                state     <= S_STORE;
                mem_we    <= we_n;
                mem_wdata <= wdata_n;
              end
            end
          end
        end
        S_STORE: begin
          state     <= S_DONE;
          completed <= 1'b1;
          result    <= '0;
        end
        S_LOAD: begin
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            completed <= 1'b1;
            result    <= ld_val;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
